register_file: RTL and testbench

// - Decode-stage general-purpose register file for the pipelined MIPS core.
// - Holds 32 x 32-bit architectural registers; $zero is hardwired to 0.
// - Two combinational read ports feed the ID/EX operands; one clocked write port
//   is driven by the writeback stage.
// - Keeps a count of accepted writes for debug/performance observation.

---
 rtl/register_file.sv | 67 ++++++
 tb/tb_register_file.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 2R/1W 32x32 decode-stage register file, $zero hardwired, counts accepted writes.
// Reads combinational, writes 1-cycle; define REGFILE_BYPASS_EN for same-cycle write-through forwarding.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic                  should_write,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [31:0]           write_count
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [31:0]           write_count_q;
  logic [31:0]           write_count_d;
  logic                  wr_accept;
  logic                  fwd_a;
  logic                  fwd_b;

  // reset_n gating keeps both the forwarding path and the counter quiet during reset
  assign wr_accept     = reset_n && should_write && (write_addr != '0);
  assign write_count_d = write_count_q + 32'd1;
  assign write_count   = write_count_q;

`ifdef REGFILE_BYPASS_EN
  assign fwd_a = wr_accept && (read_addr_a == write_addr);
  assign fwd_b = wr_accept && (read_addr_b == write_addr);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      write_count_q <= '0;
    end else if (wr_accept) begin
      regs_q[write_addr] <= write_data;
      write_count_q      <= write_count_d;
    end
  end

  always_comb begin
    read_data_a = '0;
    if (reset_n && (read_addr_a != '0)) begin
      read_data_a = fwd_a ? write_data : regs_q[read_addr_a];
    end
  end

  always_comb begin
    read_data_b = '0;
    if (reset_n && (read_addr_b != '0)) begin
      read_data_b = fwd_b ? write_data : regs_q[read_addr_b];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed writeback/read sequences checked against an array model every cycle.
`timescale 1ns/1ps
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  read_addr_a, read_addr_b, write_addr;
  logic [31:0] read_data_a, read_data_b, write_data;
  logic        should_write;
  logic [31:0] write_count;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model_regs [32];
  logic [31:0] model_count;
  logic [31:0] count_bias = 32'd0;

  always #10 clock = ~clock;

  register_file dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .read_addr_a  (read_addr_a),
    .read_addr_b  (read_addr_b),
    .read_data_a  (read_data_a),
    .read_data_b  (read_data_b),
    .should_write (should_write),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_count  (write_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural view: a write lands at the clock edge only when out of reset and not to $zero.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_count = 32'd0;
    end else if (should_write && write_addr != 5'd0) begin
      model_regs[write_addr] = write_data;
      model_count = model_count + 32'd1;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!reset_n || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (should_write && write_addr == a) return write_data;
`endif
    return model_regs[a];
  endfunction

  always @(negedge clock) begin
    #8;
    chk("cmp_read_a", read_data_a, exp_read(read_addr_a));
    chk("cmp_read_b", read_data_b, exp_read(read_addr_b));
    chk("cmp_count", write_count, model_count + count_bias);
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    #1;
    should_write = 1'b1;
    write_addr   = a;
    write_data   = d;
  endtask

  task automatic idle_read(input logic [4:0] a, input logic [4:0] b);
    @(negedge clock);
    #1;
    should_write = 1'b0;
    read_addr_a  = a;
    read_addr_b  = b;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_count  = 32'd0;
    reset_n      = 1'b1;
    should_write = 1'b0;
    write_addr   = 5'd0;
    write_data   = 32'd0;
    read_addr_a  = 5'd5;
    read_addr_b  = 5'd31;
    #1 reset_n = 1'b0;
    #4;
    chk("reset_rd_a", read_data_a, 32'd0);
    chk("reset_rd_b", read_data_b, 32'd0);
    chk("reset_count", write_count, 32'd0);
    @(negedge clock);
    #1 reset_n = 1'b1;

    // Asynchronous reset pulse mid-cycle wipes r5 and the counter
    wr(5'd5, 32'hDEAD_BEEF);
    idle_read(5'd5, 5'd5);
    #1 chk("r5_written", read_data_a, 32'hDEAD_BEEF);
    #1 reset_n = 1'b0;
    #2;
    chk("r5_after_reset", read_data_a, 32'd0);
    chk("count_after_reset", write_count, 32'd0);
    #2 reset_n = 1'b1;

    wr(5'd7, 32'h1234_5678);
    wr(5'd31, 32'hFFFF_FFFF);
    idle_read(5'd7, 5'd31);
    #4;
    chk("r7", read_data_a, 32'h1234_5678);
    chk("r31", read_data_b, 32'hFFFF_FFFF);
    chk("count_two", write_count, 32'd2);

    wr(5'd0, 32'hAAAA_AAAA);
    idle_read(5'd0, 5'd0);
    #4;
    chk("r0_a", read_data_a, 32'd0);
    chk("r0_b", read_data_b, 32'd0);
    chk("count_r0_dropped", write_count, 32'd2);

    // Same-cycle write and read of r9
    wr(5'd9, 32'h1);
    wr(5'd9, 32'h2);
    read_addr_a = 5'd9;
    #4;
`ifdef REGFILE_BYPASS_EN
    chk("r9_same_cycle", read_data_a, 32'h2);
`else
    chk("r9_same_cycle", read_data_a, 32'h1);
`endif
    idle_read(5'd9, 5'd7);
    #4;
    chk("r9_after_edge", read_data_a, 32'h2);
    chk("count_four", write_count, 32'd4);

    // Write presented while reset is held low across the edge
    wr(5'd3, 32'h55);
    read_addr_a = 5'd3;
    #4 reset_n = 1'b0;
    @(negedge clock);
    #1;
    reset_n    = 1'b1;
    write_addr = 5'd4;
    write_data = 32'h66;
    read_addr_b = 5'd4;
    #4;
    chk("r3_dropped", read_data_a, 32'd0);
    chk("count_reset_edge", write_count, 32'd0);
    idle_read(5'd3, 5'd4);
    #4;
    chk("r4_first_edge", read_data_b, 32'h66);
    chk("count_first_edge", write_count, 32'd1);

    // Counter wrap from all-ones
    @(negedge clock);
    #1 force dut.write_count_q = 32'hFFFF_FFFF;
    count_bias = 32'hFFFF_FFFF - model_count;
    #1 release dut.write_count_q;
    #1;
    chk("count_preset", write_count, 32'hFFFF_FFFF);
    should_write = 1'b1;
    write_addr   = 5'd10;
    write_data   = 32'hCAFE_F00D;
    idle_read(5'd10, 5'd4);
    #4;
    chk("count_wrapped", write_count, 32'd0);
    chk("r10", read_data_a, 32'hCAFE_F00D);

    idle_read(5'd31, 5'd9);
    idle_read(5'd0, 5'd0);
    @(negedge clock);
    #9;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
